// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, FSM state type and rotate helpers.
package des_pkg;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    // Table entries are DES bit numbers, bit 1 being the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        return cd;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        return (x >> n) | (x << (28 - n));
    endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// PC-2 compression of the 56-bit C/D pair to a 48-bit round subkey.
module des_pc2_perm import des_pkg::*; (
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    always_comb begin
        subkey = '0;
        for (int i = 0; i < 48; i++) subkey[47-i] = cd[56-PC2[i]];
    end

endmodule

// File: rtl/des_key_schedule_seq.sv
// Sequential DES/TDES subkey streamer: one 48-bit subkey per accepted beat.
// Optional key-byte odd-parity check on load: DES_KEY_PARITY_CHECK_EN.
module des_key_schedule_seq import des_pkg::*; #(
    parameter int NUM_KEYS = 3,
    parameter int ROUNDS   = 16,
    parameter int RCNT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [64*NUM_KEYS-1:0]  key_in,
    input  logic                    decrypt,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [47:0]             subkey,
    output logic                    subkey_valid,
    input  logic                    subkey_ready,
    output logic [RCNT_W-1:0]       round_idx,
    output logic [1:0]              key_idx,
    output logic                    last
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    output logic                    parity_err
`endif
);

    localparam logic [RCNT_W-1:0] LAST_RND  = RCNT_W'(ROUNDS - 1);
    localparam logic [1:0]        LAST_PASS = 2'(NUM_KEYS - 1);

    state_t                  state;
    logic [64*NUM_KEYS-1:0]  keys_r;
    logic                    dec_r;
    logic [27:0]             c_r, d_r;
    logic [55:0]             nxt_cd;
    logic [47:0]             nxt_subkey;
    logic                    xfer, pass_end, load_ok;

    // Key 0 sits in the MSBs; decrypt order walks the keys backwards.
    function automatic logic [63:0] pass_key(input logic [64*NUM_KEYS-1:0] kv,
                                             input logic dec, input int p);
        int sel;
        sel = (dec == DEC) ? p : NUM_KEYS - 1 - p;
        if (sel < 0 || sel >= NUM_KEYS) sel = 0;
        return kv[64*sel +: 64];
    endfunction

    // EDE: the middle pass runs opposite to the outer two.
    function automatic logic pass_dir(input logic dec, input int p);
        return (NUM_KEYS == 3 && p == 1) ? ~dec : dec;
    endfunction

    // Decrypt starts at K16, whose total rotation of 28 is the identity.
    function automatic logic [55:0] start_cd(input logic [63:0] key, input logic dir);
        logic [55:0] cd;
        cd = pc1(key);
        if (dir == ENC)
            cd = {rotl28(cd[55:28], SHIFTS[0]), rotl28(cd[27:0], SHIFTS[0])};
        return cd;
    endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
    function automatic logic keys_parity_ok(input logic [64*NUM_KEYS-1:0] kv);
        for (int i = 0; i < 8*NUM_KEYS; i++)
            if (^kv[8*i +: 8] == 1'b0) return 1'b0;
        return 1'b1;
    endfunction
    assign load_ok = keys_parity_ok(key_in);
`else
    assign load_ok = 1'b1;
`endif

    assign load_ready = (state == IDLE);
    assign xfer       = subkey_valid && subkey_ready;
    assign pass_end   = (round_idx == LAST_RND);

    // C/D for the beat that follows the current one (or the first beat in IDLE).
    always_comb begin
        int   r;
        logic dir;
        r      = int'(round_idx) + 1;
        dir    = pass_dir(dec_r, int'(key_idx));
        nxt_cd = {c_r, d_r};
        if (state == IDLE)
            nxt_cd = start_cd(pass_key(key_in, decrypt, 0), pass_dir(decrypt, 0));
        else if (pass_end)
            nxt_cd = start_cd(pass_key(keys_r, dec_r, int'(key_idx) + 1),
                              pass_dir(dec_r, int'(key_idx) + 1));
        else if (dir == ENC)
            nxt_cd = {rotl28(c_r, SHIFTS[r]), rotl28(d_r, SHIFTS[r])};
        else
            nxt_cd = {rotr28(c_r, SHIFTS[ROUNDS-r]), rotr28(d_r, SHIFTS[ROUNDS-r])};
    end

    des_pc2_perm u_pc2 (
        .cd     (nxt_cd),
        .subkey (nxt_subkey)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            keys_r       <= '0;
            dec_r        <= ENC;
            c_r          <= '0;
            d_r          <= '0;
            subkey       <= '0;
            subkey_valid <= 1'b0;
            round_idx    <= '0;
            key_idx      <= '0;
            last         <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_err   <= 1'b0;
`endif
        end else begin
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_err <= 1'b0;
            if (state == IDLE && load_valid && !load_ok) parity_err <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (load_valid && load_ok) begin
                        keys_r       <= key_in;
                        dec_r        <= decrypt;
                        {c_r, d_r}   <= nxt_cd;
                        subkey       <= nxt_subkey;
                        subkey_valid <= 1'b1;
                        round_idx    <= '0;
                        key_idx      <= '0;
                        last         <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (last) begin
                            subkey_valid <= 1'b0;
                            last         <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            {c_r, d_r} <= nxt_cd;
                            subkey     <= nxt_subkey;
                            if (pass_end) begin
                                round_idx <= '0;
                                key_idx   <= key_idx + 2'd1;
                                last      <= 1'b0;
                            end else begin
                                round_idx <= round_idx + 1'b1;
                                last      <= (round_idx + 1'b1 == LAST_RND) &&
                                             (key_idx == LAST_PASS);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Bench for des_key_schedule_seq: single-DES and TDES instances against a key-schedule model.
module tb_des_key_schedule_seq;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] KT  = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1V = 48'h1B02EFFC7072;
    localparam logic [47:0] K16V = 48'hCB3D8B0E17F5;

    typedef struct packed {
        logic [47:0] k;
        logic [3:0]  r;
        logic [1:0]  p;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    logic rst, dec, sr;
    logic [63:0]  k1_in;
    logic [191:0] k3_in;
    logic lv1, lr1, sv1, la1, lv3, lr3, sv3, la3;
    logic [47:0] sk1, sk3;
    logic [3:0]  ri1, ri3;
    logic [1:0]  ki1, ki3;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic pe1, pe3;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int sel = 1;

    beat_t e_b[$], g_b[$], enc_seq[$];
    int    g_c[$];

    always #5 clk = ~clk;

    des_key_schedule_seq #(.NUM_KEYS(1)) u_dut1 (
        .clk(clk), .rst(rst), .key_in(k1_in), .decrypt(dec), .load_valid(lv1),
        .load_ready(lr1), .subkey(sk1), .subkey_valid(sv1), .subkey_ready(sr),
        .round_idx(ri1), .key_idx(ki1), .last(la1)
`ifdef DES_KEY_PARITY_CHECK_EN
        , .parity_err(pe1)
`endif
    );

    des_key_schedule_seq #(.NUM_KEYS(3)) u_dut3 (
        .clk(clk), .rst(rst), .key_in(k3_in), .decrypt(dec), .load_valid(lv3),
        .load_ready(lr3), .subkey(sk3), .subkey_valid(sv3), .subkey_ready(sr),
        .round_idx(ri3), .key_idx(ki3), .last(la3)
`ifdef DES_KEY_PARITY_CHECK_EN
        , .parity_err(pe3)
`endif
    );

    logic [47:0] m_sk;
    logic [3:0]  m_ri;
    logic [1:0]  m_ki;
    logic        m_sv, m_lr, m_la;
    always_comb begin
        if (sel == 3) {m_sk, m_ri, m_ki, m_sv, m_lr, m_la} = {sk3, ri3, ki3, sv3, lr3, la3};
        else          {m_sk, m_ri, m_ki, m_sv, m_lr, m_la} = {sk1, ri1, ki1, sv1, lr1, la1};
    end

    // Kn from the textbook definition: PC-2 of C0/D0 rotated by the cumulative shift count.
    function automatic logic [47:0] ref_k(input logic [63:0] key, input int n);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        int tot;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = key[64-PC1_T[i]];
            d[27-i] = key[64-PC1_T[28+i]];
        end
        tot = 0;
        for (int j = 0; j < n; j++) tot += SH_T[j];
        repeat (tot) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
        return k;
    endfunction

    // kv holds key 0 in its top 64 bits for both instance widths.
    task automatic build_exp(input logic [191:0] kv, input int nk, input bit dm);
        logic [63:0] key;
        int kn;
        bit dr;
        beat_t b;
        e_b.delete();
        for (int p = 0; p < nk; p++) begin
            kn  = (nk == 3 && dm) ? 2 - p : p;
            dr  = (nk == 3 && p == 1) ? !dm : dm;
            key = kv[191-64*kn -: 64];
            for (int r = 0; r < 16; r++) begin
                b.k = ref_k(key, dr ? 16 - r : r + 1);
                b.r = 4'(r);
                b.p = 2'(p);
                b.l = (p == nk - 1) && (r == 15);
                e_b.push_back(b);
            end
        end
    endtask

    function automatic logic [191:0] mkkey();
        logic [191:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
`ifdef DES_KEY_PARITY_CHECK_EN
        for (int b = 0; b < 24; b++) if (^v[8*b +: 8] == 1'b0) v[8*b] = ~v[8*b];
`endif
        return v;
    endfunction

    task automatic do_load(input int s, input logic [191:0] kv, input bit dm);
        sel = s;
        dec = dm;
        if (s == 3) begin k3_in = kv; lv3 = 1'b1; end
        else        begin k1_in = kv[191:128]; lv1 = 1'b1; end
        @(posedge clk); #1;
        lv1 = 1'b0;
        lv3 = 1'b0;
    endtask

    // Collects beats with ready held high, scrambling inputs the DUT must ignore.
    task automatic collect(input int n, input int budget, output bit to);
        int cyc;
        beat_t b;
        cyc = 0;
        g_b.delete();
        g_c.delete();
        sr = 1'b1;
        while (g_b.size() < n && cyc < budget) begin
            if (m_sv) begin
                b = '{k: m_sk, r: m_ri, p: m_ki, l: m_la};
                g_b.push_back(b);
                g_c.push_back(cyc);
            end
            k1_in = {$urandom(), $urandom()};
            k3_in = mkkey();
            dec   = 1'($urandom_range(1));
            if (sel == 3) lv3 = 1'($urandom_range(1));
            else          lv1 = 1'($urandom_range(1));
            @(posedge clk); #1;
            cyc++;
        end
        lv1 = 1'b0;
        lv3 = 1'b0;
        to = (g_b.size() < n);
    endtask

    task automatic test_reset();
        rst = 1'b1; sr = 1'b0; dec = 1'b0; lv1 = 1'b0; lv3 = 1'b0;
        k1_in = '0; k3_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run += 8;
        if (sv1 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid1: got %b want 0", sv1); end
        if (lr1 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready1: got %b want 1", lr1); end
        if ({sk1, ri1, ki1, la1} !== 55'd0) begin tests_failed++; $display("FAIL reset_out1: got %h %h %h %b want 0", sk1, ri1, ki1, la1); end
        if (sv3 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid3: got %b want 0", sv3); end
        if (lr3 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready3: got %b want 1", lr3); end
        if (sk3 !== 48'd0) begin tests_failed++; $display("FAIL reset_subkey3: got %h want 0", sk3); end
        if (ri3 !== 4'd0 || ki3 !== 2'd0) begin tests_failed++; $display("FAIL reset_idx3: got %h %h want 0 0", ri3, ki3); end
        if (la3 !== 1'b0) begin tests_failed++; $display("FAIL reset_last3: got %b want 0", la3); end
    endtask

    task automatic test_known(input bit dm);
        bit to;
        build_exp({KT, 128'd0}, 1, dm);
        tests_run++;
        if (lr1 !== 1'b1) begin tests_failed++; $display("FAIL known_ready: got %b want 1", lr1); end
        do_load(1, {KT, 128'd0}, dm);
        collect(16, 40, to);
        tests_run += 5;
        if (to) begin tests_failed++; $display("FAIL known_timeout dm=%0d: got %0d beats want 16", dm, g_b.size()); end
        if (g_b[0].k !== (dm ? K16V : K1V)) begin tests_failed++; $display("FAIL known_first dm=%0d: got %h want %h", dm, g_b[0].k, dm ? K16V : K1V); end
        if (g_b[15].k !== (dm ? K1V : K16V)) begin tests_failed++; $display("FAIL known_last_key dm=%0d: got %h want %h", dm, g_b[15].k, dm ? K1V : K16V); end
        if (m_sv !== 1'b0) begin tests_failed++; $display("FAIL known_valid_drop dm=%0d: got %b want 0", dm, m_sv); end
        if (m_lr !== 1'b1) begin tests_failed++; $display("FAIL known_ready_back dm=%0d: got %b want 1", dm, m_lr); end
        for (int i = 0; i < g_b.size(); i++) begin
            tests_run += 2;
            if (g_b[i] !== e_b[i]) begin tests_failed++; $display("FAIL known_beat dm=%0d i=%0d: got %h want %h", dm, i, g_b[i], e_b[i]); end
            if (g_c[i] !== i) begin tests_failed++; $display("FAIL known_cycle dm=%0d i=%0d: got %0d want %0d", dm, i, g_c[i], i); end
            if (dm && enc_seq.size() == 16) begin
                tests_run++;
                if (g_b[i].k !== enc_seq[15-i].k) begin tests_failed++; $display("FAIL known_reverse i=%0d: got %h want %h", i, g_b[i].k, enc_seq[15-i].k); end
            end
        end
        if (!dm) enc_seq = g_b;
    endtask

    task automatic test_tdes_same();
        bit to;
        build_exp({KT, KT, KT}, 3, 1'b0);
        do_load(3, {KT, KT, KT}, 1'b0);
        collect(48, 80, to);
        tests_run += 5;
        if (to) begin tests_failed++; $display("FAIL tdes_timeout: got %0d beats want 48", g_b.size()); end
        if (g_b[16].k !== K16V) begin tests_failed++; $display("FAIL tdes_pass1_first: got %h want %h", g_b[16].k, K16V); end
        if ({g_b[0].p, g_b[16].p, g_b[32].p} !== 6'b00_01_10) begin tests_failed++; $display("FAIL tdes_key_idx: got %h %h %h want 0 1 2", g_b[0].p, g_b[16].p, g_b[32].p); end
        if (g_c[47] !== 47) begin tests_failed++; $display("FAIL tdes_no_bubble: got %0d want 47", g_c[47]); end
        if (m_sv !== 1'b0) begin tests_failed++; $display("FAIL tdes_valid_drop: got %b want 0", m_sv); end
        for (int i = 0; i < g_b.size(); i++) begin
            tests_run += 2;
            if (g_b[i].l !== (i == 47)) begin tests_failed++; $display("FAIL tdes_last i=%0d: got %b want %b", i, g_b[i].l, i == 47); end
            if (g_b[i] !== e_b[i]) begin tests_failed++; $display("FAIL tdes_beat i=%0d: got %h want %h", i, g_b[i], e_b[i]); end
        end
    endtask

    task automatic test_random();
        bit to, dm;
        int s, n;
        logic [191:0] kv;
        for (int it = 0; it < 8; it++) begin
            s  = (it % 2) ? 3 : 1;
            n  = 16 * s;
            kv = mkkey();
            if (s == 1) kv[127:0] = '0;
            dm = 1'($urandom_range(1));
            build_exp(kv, s, dm);
            do_load(s, kv, dm);
            collect(n, n + 20, to);
            tests_run += 2;
            if (to) begin tests_failed++; $display("FAIL rand_timeout it=%0d: got %0d beats want %0d", it, g_b.size(), n); end
            if (m_sv !== 1'b0) begin tests_failed++; $display("FAIL rand_reload_ignored it=%0d: got valid %b want 0", it, m_sv); end
            for (int i = 0; i < g_b.size(); i++) begin
                tests_run++;
                if (g_b[i] !== e_b[i]) begin tests_failed++; $display("FAIL rand_beat it=%0d i=%0d: got %h want %h", it, i, g_b[i], e_b[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit dm, stalled, rdy;
        int cyc;
        beat_t h, b;
        logic [191:0] kv;
        kv = mkkey();
        dm = 1'($urandom_range(1));
        build_exp(kv, 3, dm);
        do_load(3, kv, dm);
        g_b.delete();
        stalled = 1'b0;
        h = '0;
        cyc = 0;
        while (g_b.size() < 48 && cyc < 600) begin
            b = '{k: m_sk, r: m_ri, p: m_ki, l: m_la};
            if (stalled) begin
                tests_run += 2;
                if (m_sv !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_hold cyc=%0d: got %b want 1", cyc, m_sv); end
                if (b !== h) begin tests_failed++; $display("FAIL bp_stable cyc=%0d: got %h want %h", cyc, b, h); end
            end
            rdy = 1'($urandom_range(1));
            sr = rdy;
            stalled = 1'b0;
            if (m_sv && rdy) g_b.push_back(b);
            else if (m_sv) begin stalled = 1'b1; h = b; end
            @(posedge clk); #1;
            cyc++;
        end
        sr = 1'b1;
        tests_run++;
        if (g_b.size() != 48) begin tests_failed++; $display("FAIL bp_count: got %0d want 48", g_b.size()); end
        for (int i = 0; i < g_b.size(); i++) begin
            tests_run++;
            if (g_b[i] !== e_b[i]) begin tests_failed++; $display("FAIL bp_beat i=%0d: got %h want %h", i, g_b[i], e_b[i]); end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit to;
        int cyc;
        logic [191:0] kv;
        kv = mkkey();
        kv[127:0] = '0;
        do_load(1, kv, 1'b0);
        sr = 1'b1;
        cyc = 0;
        while (m_ri !== 4'd7 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        tests_run++;
        if (m_ri !== 4'd7 || m_sv !== 1'b1) begin tests_failed++; $display("FAIL mid_reach7: got round %0d valid %b want 7 1", m_ri, m_sv); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run += 3;
        if (m_sv !== 1'b0) begin tests_failed++; $display("FAIL mid_abort_valid: got %b want 0", m_sv); end
        if (m_lr !== 1'b1) begin tests_failed++; $display("FAIL mid_abort_ready: got %b want 1", m_lr); end
        @(posedge clk); #1;
        if (m_sv !== 1'b0) begin tests_failed++; $display("FAIL mid_no_more: got %b want 0", m_sv); end
        kv = mkkey();
        kv[127:0] = '0;
        build_exp(kv, 1, 1'b1);
        do_load(1, kv, 1'b1);
        collect(16, 40, to);
        tests_run += 2;
        if (to) begin tests_failed++; $display("FAIL mid_restart_timeout: got %0d beats want 16", g_b.size()); end
        if (g_b[0].r !== 4'd0) begin tests_failed++; $display("FAIL mid_restart_round: got %0d want 0", g_b[0].r); end
        for (int i = 0; i < g_b.size(); i++) begin
            tests_run++;
            if (g_b[i] !== e_b[i]) begin tests_failed++; $display("FAIL mid_beat i=%0d: got %h want %h", i, g_b[i], e_b[i]); end
        end
    endtask

`ifdef DES_KEY_PARITY_CHECK_EN
    task automatic test_parity();
        int pulses;
        bit seen_valid;
        pulses = 0;
        seen_valid = 1'b0;
        do_load(1, {64'h133457799BBCDFF0, 128'd0}, 1'b0);
        for (int c = 0; c < 6; c++) begin
            pulses += int'(pe1);
            if (sv1) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        tests_run += 3;
        if (pulses != 1) begin tests_failed++; $display("FAIL parity_pulse: got %0d want 1", pulses); end
        if (seen_valid) begin tests_failed++; $display("FAIL parity_no_subkey: got valid want none"); end
        if (lr1 !== 1'b1) begin tests_failed++; $display("FAIL parity_idle: got ready %b want 1", lr1); end
    endtask
`endif

    initial begin
        test_reset();
        test_known(1'b0);
        test_known(1'b1);
        test_tdes_same();
        test_random();
        test_backpressure();
        test_reset_mid();
`ifdef DES_KEY_PARITY_CHECK_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
